// File: rtl/virtex_cfg_packet_ctrl.sv
// Virtex configuration packet controller: SYNC hunt, Type 1/2 header decode, register strobes, FDRI streaming.
// Latency: strobes, hdr_err and frame_vld appear one cycle after the accepting edge.
// Backpressure: cfg_word_rdy is high except in FDRI while an unaccepted frame word is held (frame_rdy low).
module virtex_cfg_packet_ctrl #(
    parameter int WC_W = 20
) (
    input  logic        cclk,
    input  logic        por,
    input  logic [31:0] cfg_word,
    input  logic        cfg_word_vld,
    output logic        cfg_word_rdy,
    output logic        reg_wr_stb,
    output logic [3:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_rd_stb,
    output logic [31:0] frame_data,
    output logic        frame_vld,
    input  logic        frame_rdy,
    output logic        synced,
    output logic        start_stb,
    output logic        done,
    output logic        hdr_err
);

    localparam logic [31:0] SYNC_WORD  = 32'hAA995566;
    localparam logic [2:0]  TYPE1      = 3'b001;
    localparam logic [2:0]  TYPE2      = 3'b010;
    localparam logic [1:0]  OP_READ    = 2'b01;
    localparam logic [1:0]  OP_WRITE   = 2'b10;
    localparam logic [1:0]  OP_ILLEGAL = 2'b11;
    localparam logic [3:0]  ADDR_FDRI  = 4'h2;
    localparam logic [3:0]  ADDR_CMD   = 4'h4;
    localparam logic [3:0]  CMD_START  = 4'h5;
    localparam logic [3:0]  CMD_DESYNC = 4'hD;

    typedef enum logic [1:0] {S_HUNT, S_HDR, S_REG, S_FDRI} state_t;

    state_t          state;
    logic [3:0]      addr;
    logic [3:0]      last_addr;
    logic            last_addr_valid;
    logic [WC_W-1:0] wc;

    logic            accept;
    logic            frame_take;
    logic [2:0]      hdr_type;
    logic [1:0]      hdr_op;
    logic [3:0]      t1_addr;
    logic [WC_W-1:0] t1_wc;
    logic [WC_W-1:0] t2_wc;
    logic            hdr_bad;

    always_comb begin
        cfg_word_rdy = por && ((state != S_FDRI) || !frame_vld || frame_rdy);
        accept       = cfg_word_vld && cfg_word_rdy;
        frame_take   = frame_vld && frame_rdy;
        hdr_type     = cfg_word[31:29];
        hdr_op       = cfg_word[28:27];
        t1_addr      = cfg_word[16:13];
        t1_wc        = {{(WC_W-11){1'b0}}, cfg_word[10:0]};
        t2_wc        = cfg_word[WC_W-1:0];
        hdr_bad      = (hdr_op == OP_ILLEGAL) ||
                       !((hdr_type == TYPE1) || (hdr_type == TYPE2 && last_addr_valid));
    end

    // FDRI words are counted as they enter the output register, so the
    // next header can be taken on the cycle after the last data word.
    always_ff @(posedge cclk or negedge por) begin
        if (!por) begin
            state           <= S_HUNT;
            addr            <= '0;
            last_addr       <= '0;
            last_addr_valid <= 1'b0;
            wc              <= '0;
            reg_wr_stb      <= 1'b0;
            reg_rd_stb      <= 1'b0;
            reg_addr        <= '0;
            reg_wdata       <= '0;
            frame_data      <= '0;
            frame_vld       <= 1'b0;
            synced          <= 1'b0;
            start_stb       <= 1'b0;
            done            <= 1'b0;
            hdr_err         <= 1'b0;
        end else begin
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
            start_stb  <= 1'b0;
            hdr_err    <= 1'b0;
            if (frame_take)
                frame_vld <= 1'b0;
            if (accept) begin
                case (state)
                    S_HUNT: begin
                        if (cfg_word == SYNC_WORD) begin
                            synced          <= 1'b1;
                            last_addr_valid <= 1'b0;
                            state           <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (hdr_bad) begin
                            hdr_err <= 1'b1;
                            synced  <= 1'b0;
                            state   <= S_HUNT;
                        end else if (hdr_type == TYPE1) begin
                            if (hdr_op == OP_WRITE) begin
                                last_addr <= t1_addr;
                                if (t1_wc != '0) begin
                                    addr  <= t1_addr;
                                    wc    <= t1_wc;
                                    state <= (t1_addr == ADDR_FDRI) ? S_FDRI : S_REG;
                                end else begin
                                    last_addr_valid <= 1'b1;
                                end
                            end else if (hdr_op == OP_READ) begin
                                reg_rd_stb <= 1'b1;
                                reg_addr   <= t1_addr;
                            end
                        end else if (hdr_op == OP_WRITE) begin
                            wc   <= t2_wc;
                            addr <= last_addr;
                            if (t2_wc != '0)
                                state <= (last_addr == ADDR_FDRI) ? S_FDRI : S_REG;
                        end
                    end
                    S_REG: begin
                        reg_wr_stb <= 1'b1;
                        reg_addr   <= addr;
                        reg_wdata  <= cfg_word;
                        wc         <= wc - 1'b1;
                        if (wc == WC_W'(1))
                            state <= S_HDR;
                        if (addr == ADDR_CMD && cfg_word[3:0] == CMD_START) begin
                            start_stb <= 1'b1;
                            done      <= 1'b1;
                        end else if (addr == ADDR_CMD && cfg_word[3:0] == CMD_DESYNC) begin
                            synced <= 1'b0;
                            state  <= S_HUNT;
                        end
                    end
                    S_FDRI: begin
                        frame_data <= cfg_word;
                        frame_vld  <= 1'b1;
                        wc         <= wc - 1'b1;
                        if (wc == WC_W'(1))
                            state <= S_HDR;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_virtex_cfg_packet_ctrl.sv
// Directed bench for virtex_cfg_packet_ctrl: vector table for header/register flow plus FDRI, stall and reset sequences.
module tb_virtex_cfg_packet_ctrl;

    logic        cclk = 1'b0;
    logic        por = 1'b0;
    logic [31:0] cfg_word = '0;
    logic        cfg_word_vld = 1'b0;
    logic        cfg_word_rdy;
    logic        reg_wr_stb;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_rd_stb;
    logic [31:0] frame_data;
    logic        frame_vld;
    logic        frame_rdy = 1'b1;
    logic        synced;
    logic        start_stb;
    logic        done;
    logic        hdr_err;

    virtex_cfg_packet_ctrl #(.WC_W(20)) dut (
        .cclk(cclk), .por(por),
        .cfg_word(cfg_word), .cfg_word_vld(cfg_word_vld), .cfg_word_rdy(cfg_word_rdy),
        .reg_wr_stb(reg_wr_stb), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rd_stb(reg_rd_stb),
        .frame_data(frame_data), .frame_vld(frame_vld), .frame_rdy(frame_rdy),
        .synced(synced), .start_stb(start_stb), .done(done), .hdr_err(hdr_err)
    );

    always #5 cclk = ~cclk;

    int checks = 0;
    int errors = 0;
    logic [31:0] fq[$];

    always @(negedge cclk)
        if (por && frame_vld && frame_rdy)
            fq.push_back(frame_data);

    // {wr, rd, start, done, err, synced}
    typedef struct {
        logic [31:0] word;
        logic [5:0]  f;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge cclk);
        cfg_word     = w;
        cfg_word_vld = 1'b1;
        while (!cfg_word_rdy && n < 100) begin
            @(negedge cclk);
            n++;
        end
        if (!cfg_word_rdy) begin
            chk("send_timeout_rdy", 64'(cfg_word_rdy), 64'd1);
            cfg_word_vld = 1'b0;
            return;
        end
        @(posedge cclk);
        #1;
        cfg_word_vld = 1'b0;
    endtask

    function automatic logic [5:0] flags();
        return {reg_wr_stb, reg_rd_stb, start_stb, done, hdr_err, synced};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'hFFFFFFFF, 6'b000000, 4'h0, 32'h0};
        vecs[1]  = '{32'h00000000, 6'b000000, 4'h0, 32'h0};
        vecs[2]  = '{32'hAA995566, 6'b000001, 4'h0, 32'h0};
        vecs[3]  = '{32'h30008001, 6'b000001, 4'h0, 32'h0};
        vecs[4]  = '{32'h00000005, 6'b101101, 4'h4, 32'h00000005};
        vecs[5]  = '{32'h20000000, 6'b000101, 4'h0, 32'h0};
        vecs[6]  = '{32'h2800E000, 6'b010101, 4'h7, 32'h0};
        vecs[7]  = '{32'h30002001, 6'b000101, 4'h0, 32'h0};
        vecs[8]  = '{32'h12345678, 6'b100101, 4'h1, 32'h12345678};
        vecs[9]  = '{32'h30008001, 6'b000101, 4'h0, 32'h0};
        vecs[10] = '{32'h0000000D, 6'b100100, 4'h4, 32'h0000000D};
        vecs[11] = '{32'h30008001, 6'b000100, 4'h0, 32'h0};
        vecs[12] = '{32'h00000005, 6'b000100, 4'h0, 32'h0};
        vecs[13] = '{32'hAA995566, 6'b000101, 4'h0, 32'h0};
        vecs[14] = '{32'h50000002, 6'b000110, 4'h0, 32'h0};
        vecs[15] = '{32'hAA995566, 6'b000101, 4'h0, 32'h0};
        vecs[16] = '{32'h38000000, 6'b000110, 4'h0, 32'h0};
        vecs[17] = '{32'hAA995566, 6'b000101, 4'h0, 32'h0};
        vecs[18] = '{32'h30008000, 6'b000101, 4'h0, 32'h0};
        vecs[19] = '{32'h50000001, 6'b000101, 4'h0, 32'h0};
        vecs[20] = '{32'h00000005, 6'b101101, 4'h4, 32'h00000005};
        vecs[21] = '{32'hE0000000, 6'b000110, 4'h0, 32'h0};

        repeat (3) @(posedge cclk);
        #1;
        chk("reset_ctrl", 64'({cfg_word_rdy, flags(), frame_vld}), 64'd0);
        chk("reset_data", {reg_wdata, frame_data}, 64'd0);
        chk("reset_addr", 64'(reg_addr), 64'd0);
        @(negedge cclk);
        por = 1'b1;
        #1;
        chk("rdy_after_reset", 64'(cfg_word_rdy), 64'd1);

        for (int i = 0; i < 22; i++) begin
            send(vecs[i].word);
            chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].f));
            if (vecs[i].f[5] || vecs[i].f[4])
                chk($sformatf("vec%0d_addr", i), 64'(reg_addr), 64'(vecs[i].addr));
            if (vecs[i].f[5])
                chk($sformatf("vec%0d_wdata", i), 64'(reg_wdata), 64'(vecs[i].wdata));
        end

        // FDRI via Type 1 WC=0 then Type 2, frame_rdy held high
        send(32'hAA995566);
        send(32'h30004000);
        send(32'h50000003);
        fq.delete();
        send(32'hD0000001);
        send(32'hD0000002);
        send(32'hD0000003);
        send(32'h2800E000);
        chk("fdri_back_to_hdr", 64'({reg_rd_stb, reg_wr_stb, reg_addr}), 64'({1'b1, 1'b0, 4'h7}));
        repeat (2) @(negedge cclk);
        chk("fdri_count", 64'(fq.size()), 64'd3);
        for (int i = 0; i < 3 && i < fq.size(); i++)
            chk($sformatf("fdri_word%0d", i), 64'(fq[i]), 64'(32'hD0000001 + i));

        // FDRI with frame_rdy low for 4 cycles mid-stream
        fq.delete();
        send(32'h50000003);
        send(32'hA0000001);
        frame_rdy = 1'b0;
        fork
            begin
                send(32'hA0000002);
                send(32'hA0000003);
            end
            begin
                repeat (4) begin
                    @(negedge cclk);
                    chk("stall_rdy_low", 64'(cfg_word_rdy), 64'd0);
                    chk("stall_data_held", 64'({frame_vld, frame_data}), 64'({1'b1, 32'hA0000001}));
                end
                @(posedge cclk);
                #1;
                frame_rdy = 1'b1;
            end
        join
        send(32'h2800E000);
        chk("stall_back_to_hdr", 64'(reg_rd_stb), 64'd1);
        repeat (2) @(negedge cclk);
        chk("stall_count", 64'(fq.size()), 64'd3);
        for (int i = 0; i < 3 && i < fq.size(); i++)
            chk($sformatf("stall_word%0d", i), 64'(fq[i]), 64'(32'hA0000001 + i));

        // por pulsed mid-FDRI with five words outstanding
        send(32'h50000006);
        frame_rdy = 1'b0;
        send(32'hB0000001);
        chk("por_pre_state", 64'({frame_vld, synced, done}), 64'(3'b111));
        #2;
        por = 1'b0;
        #1;
        chk("por_ctrl_zero", 64'({cfg_word_rdy, flags(), frame_vld}), 64'd0);
        chk("por_data_zero", {reg_wdata, frame_data}, 64'd0);
        @(negedge cclk);
        por = 1'b1;
        frame_rdy = 1'b1;
        send(32'h30008001);
        chk("por_hunt_hdr", 64'(flags()), 64'd0);
        send(32'h00000005);
        chk("por_hunt_data", 64'(flags()), 64'd0);
        send(32'hAA995566);
        chk("por_resync", 64'(flags()), 64'(6'b000001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
